// File: rtl/fw_mailbox_wb.sv
// Wishbone mailbox that firmware uses to report progress to the testbench:
// event pulses, expected/measured compare, error counter and a message FIFO.
module fw_mailbox_wb #(
    parameter int FIFO_DEPTH = 64,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic [31:0]                 wb_adr_i,
    input  logic [31:0]                 wb_dat_i,
    input  logic [3:0]                  wb_sel_i,
    input  logic                        wb_we_i,
    input  logic                        wb_cyc_i,
    input  logic                        wb_stb_i,
    output logic                        wb_ack_o,
    output logic                        wb_err_o,
    output logic [31:0]                 wb_dat_o,
    output logic                        evt_report_o,
    output logic                        evt_warning_o,
    output logic                        evt_error_o,
    output logic                        cmp_done_o,
    output logic                        cmp_pass_o,
    input  logic                        msg_rd_i,
    output logic [7:0]                  msg_data_o,
    output logic                        msg_empty_o,
    output logic                        msg_full_o,
    output logic [$clog2(FIFO_DEPTH):0] msg_level_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int OW = ADDR_WIDTH - 2;

    localparam logic [OW-1:0] OFF_CONTROL   = OW'(0);
    localparam logic [OW-1:0] OFF_STATUS    = OW'(1);
    localparam logic [OW-1:0] OFF_EXPECTED  = OW'(2);
    localparam logic [OW-1:0] OFF_MEASURED  = OW'(3);
    localparam logic [OW-1:0] OFF_MSG_DATA  = OW'(4);
    localparam logic [OW-1:0] OFF_ERR_COUNT = OW'(5);

    logic                 ack_q, ack_d, err_q, err_d;
    logic [31:0]          dat_q, dat_d;
    logic [2:0]           evt_q, evt_d;
    logic                 cmp_done_q, cmp_done_d, cmp_pass_q, cmp_pass_d;
    logic [31:0]          exp_q, exp_d, meas_q, meas_d;
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                 ovf_q, ovf_d;
    logic [LW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]           mem_q [FIFO_DEPTH];

    logic [OW-1:0]  offset;
    logic           accept, mapped, wr_en, rd_en;
    logic           wr_ctrl, cmp_exec, cmp_fail, flush, push_req, pop_req, push_ok;
    logic [LW-1:0]  level;
    logic           empty, full;
    logic [1:0]     err_inc;
    logic [CNT_WIDTH:0] err_sum;
    logic           unused_adr;

    // Only the word offset inside the peripheral window is decoded.
    assign unused_adr = ^{wb_adr_i[31:ADDR_WIDTH], wb_adr_i[1:0]};
    assign offset     = wb_adr_i[ADDR_WIDTH-1:2];
    assign accept     = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
    assign mapped     = (offset <= OFF_ERR_COUNT);
    assign wr_en      = accept & wb_we_i & mapped;
    assign rd_en      = accept & ~wb_we_i & mapped;

    assign level = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (level == LW'(FIFO_DEPTH));

    assign wr_ctrl  = wr_en & (offset == OFF_CONTROL);
    assign cmp_exec = wr_ctrl & wb_dat_i[3];
    assign cmp_fail = cmp_exec & (exp_q != meas_q);
    assign flush    = wr_ctrl & wb_dat_i[4];
    assign push_req = wr_en & (offset == OFF_MSG_DATA) & wb_sel_i[0];
    assign pop_req  = msg_rd_i & ~empty;
    // A push into a full FIFO only lands when the same edge frees a slot.
    assign push_ok  = push_req & (~full | pop_req);

    assign err_inc = {1'b0, wr_ctrl & wb_dat_i[2]} + {1'b0, cmp_fail};
    assign err_sum = {1'b0, err_cnt_q} + (CNT_WIDTH+1)'(err_inc);

    always_comb begin
        // NOTE: every _d gets a default first so no path can infer a latch.
        ack_d      = accept & mapped;
        err_d      = accept & ~mapped;
        dat_d      = '0;
        evt_d      = wr_ctrl ? wb_dat_i[2:0] : 3'b000;
        cmp_done_d = cmp_exec;
        cmp_pass_d = cmp_exec ? (exp_q == meas_q) : cmp_pass_q;
        exp_d      = exp_q;
        meas_d     = meas_q;
        err_cnt_d  = err_sum[CNT_WIDTH] ? '1 : err_sum[CNT_WIDTH-1:0];
        ovf_d      = ovf_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        if (rd_en) begin
            unique case (offset)
                OFF_STATUS:    dat_d = {16'h0, 8'(level), 5'h0, ovf_q, full, empty};
                OFF_EXPECTED:  dat_d = exp_q;
                OFF_MEASURED:  dat_d = meas_q;
                OFF_ERR_COUNT: dat_d = 32'(err_cnt_q);
                default:       dat_d = '0;
            endcase
        end

        for (int i = 0; i < 4; i++) begin
            if (wr_en && offset == OFF_EXPECTED && wb_sel_i[i])
                exp_d[8*i +: 8] = wb_dat_i[8*i +: 8];
            if (wr_en && offset == OFF_MEASURED && wb_sel_i[i])
                meas_d[8*i +: 8] = wb_dat_i[8*i +: 8];
        end

        if (wr_en && offset == OFF_ERR_COUNT) err_cnt_d = '0;
        if (wr_en && offset == OFF_STATUS && wb_dat_i[2]) ovf_d = 1'b0;
        if (push_req && full && !pop_req) ovf_d = 1'b1;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + LW'(1);
            if (pop_req) rd_ptr_d = rd_ptr_q + LW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dat_q      <= '0;
            evt_q      <= '0;
            cmp_done_q <= 1'b0;
            cmp_pass_q <= 1'b0;
            exp_q      <= '0;
            meas_q     <= '0;
            err_cnt_q  <= '0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            ack_q      <= ack_d;
            err_q      <= err_d;
            dat_q      <= dat_d;
            evt_q      <= evt_d;
            cmp_done_q <= cmp_done_d;
            cmp_pass_q <= cmp_pass_d;
            exp_q      <= exp_d;
            meas_q     <= meas_d;
            err_cnt_q  <= err_cnt_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // NOTE: the storage array has no reset; emptiness comes from the pointers.
    always_ff @(posedge wb_clk_i) begin
        if (push_ok) mem_q[wr_ptr_q[PW-1:0]] <= wb_dat_i[7:0];
    end

    assign wb_ack_o      = ack_q;
    assign wb_err_o      = err_q;
    assign wb_dat_o      = dat_q;
    assign evt_report_o  = evt_q[0];
    assign evt_warning_o = evt_q[1];
    assign evt_error_o   = evt_q[2];
    assign cmp_done_o    = cmp_done_q;
    assign cmp_pass_o    = cmp_pass_q;
    assign msg_data_o    = empty ? 8'h00 : mem_q[rd_ptr_q[PW-1:0]];
    assign msg_empty_o   = empty;
    assign msg_full_o    = full;
    assign msg_level_o   = level;
endmodule

// File: tb/tb_fw_mailbox_wb.sv
// Directed self-checking bench for fw_mailbox_wb, built with a 4-entry FIFO
// so the overflow and wrap cases are reachable in a few accesses.
module tb_fw_mailbox_wb;
    localparam logic [31:0] A_CTRL = 32'h00, A_STAT = 32'h04, A_EXP = 32'h08;
    localparam logic [31:0] A_MEAS = 32'h0C, A_MSG = 32'h10, A_ERRC = 32'h14;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr, wdat, rdat;
    logic [3:0]  sel;
    logic        we, cyc, stb, ack, err;
    logic        evt_rep, evt_warn, evt_err, cmp_done, cmp_pass;
    logic        msg_rd, msg_empty, msg_full;
    logic [7:0]  msg_data;
    logic [2:0]  msg_level;

    int n_cmp = 0;
    int n_bad = 0;

    logic        s_ack, s_err, s_cmpdone, s_cmppass, n_ack, n_err, n_cmpdone;
    logic [31:0] s_dat;
    logic [2:0]  s_evt, n_evt;

    fw_mailbox_wb #(.FIFO_DEPTH(4), .ADDR_WIDTH(8), .CNT_WIDTH(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat),
        .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_ack_o(ack), .wb_err_o(err), .wb_dat_o(rdat),
        .evt_report_o(evt_rep), .evt_warning_o(evt_warn), .evt_error_o(evt_err),
        .cmp_done_o(cmp_done), .cmp_pass_o(cmp_pass),
        .msg_rd_i(msg_rd), .msg_data_o(msg_data), .msg_empty_o(msg_empty),
        .msg_full_o(msg_full), .msg_level_o(msg_level)
    );

    always #5 clk = ~clk;

    // One access: drive, sample the response cycle, then the cycle after it.
    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic w, input logic pop);
        adr = a; wdat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1; msg_rd = pop;
        @(posedge clk); #1;
        s_ack = ack; s_err = err; s_dat = rdat; s_evt = {evt_err, evt_warn, evt_rep};
        s_cmpdone = cmp_done; s_cmppass = cmp_pass;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; msg_rd = 1'b0;
        @(posedge clk); #1;
        n_ack = ack; n_err = err; n_evt = {evt_err, evt_warn, evt_rep}; n_cmpdone = cmp_done;
    endtask

    task automatic pop_one();
        msg_rd = 1'b1;
        @(posedge clk); #1;
        msg_rd = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if ({ack, err, rdat} !== 34'h0) begin n_bad++; $display("FAIL reset_bus: got %h want 0", {ack, err, rdat}); end
        n_cmp++; if ({evt_rep, evt_warn, evt_err, cmp_done, cmp_pass} !== 5'b0) begin n_bad++; $display("FAIL reset_evt: got %b want 00000", {evt_rep, evt_warn, evt_err, cmp_done, cmp_pass}); end
        n_cmp++; if ({msg_empty, msg_full, msg_level, msg_data} !== {1'b1, 1'b0, 3'd0, 8'h00}) begin n_bad++; $display("FAIL reset_fifo: got %h want %h", {msg_empty, msg_full, msg_level, msg_data}, {1'b1, 1'b0, 3'd0, 8'h00}); end
        rst = 1'b0;
        bus(A_STAT, 0, 4'hF, 1'b0, 1'b0);
        n_cmp++; if (s_dat !== 32'h1) begin n_bad++; $display("FAIL reset_status: got %h want 00000001", s_dat); end
    endtask

    task automatic test_events();
        bus(A_CTRL, 32'h7, 4'hF, 1'b1, 1'b0);
        n_cmp++; if ({s_ack, s_err, n_ack} !== 3'b100) begin n_bad++; $display("FAIL evt_ack: got %b want 100", {s_ack, s_err, n_ack}); end
        n_cmp++; if (s_evt !== 3'b111) begin n_bad++; $display("FAIL evt_pulse: got %b want 111", s_evt); end
        n_cmp++; if (n_evt !== 3'b000) begin n_bad++; $display("FAIL evt_one_cycle: got %b want 000", n_evt); end
        bus(A_ERRC, 0, 4'hF, 1'b0, 1'b0);
        n_cmp++; if (s_dat !== 32'd1) begin n_bad++; $display("FAIL evt_errcnt: got %0d want 1", s_dat); end
    endtask

    task automatic test_compare();
        bus(A_EXP, 32'h12345678, 4'hF, 1'b1, 1'b0);
        bus(A_MEAS, 32'hAB345678, 4'h7, 1'b1, 1'b0);
        bus(A_MEAS, 0, 4'hF, 1'b0, 1'b0);
        n_cmp++; if (s_dat !== 32'h00345678) begin n_bad++; $display("FAIL cmp_meas_lanes: got %h want 00345678", s_dat); end
        bus(A_CTRL, 32'h8, 4'hF, 1'b1, 1'b0);
        n_cmp++; if ({s_cmpdone, s_cmppass, n_cmpdone, s_evt} !== 6'b100000) begin n_bad++; $display("FAIL cmp_fail: got %b want 100000", {s_cmpdone, s_cmppass, n_cmpdone, s_evt}); end
        bus(A_ERRC, 0, 4'hF, 1'b0, 1'b0);
        n_cmp++; if (s_dat !== 32'd2) begin n_bad++; $display("FAIL cmp_errcnt: got %0d want 2", s_dat); end
        bus(A_MEAS, 32'h12000000, 4'h8, 1'b1, 1'b0);
        bus(A_CTRL, 32'h8, 4'hF, 1'b1, 1'b0);
        n_cmp++; if ({s_cmpdone, s_cmppass} !== 2'b11) begin n_bad++; $display("FAIL cmp_pass: got %b want 11", {s_cmpdone, s_cmppass}); end
        bus(A_MEAS, 32'h0, 4'h1, 1'b1, 1'b0);
        bus(A_CTRL, 32'hC, 4'hF, 1'b1, 1'b0);
        n_cmp++; if ({s_cmppass, s_evt} !== 4'b0100) begin n_bad++; $display("FAIL cmp_err_both: got %b want 0100", {s_cmppass, s_evt}); end
        bus(A_CTRL, 32'h1, 4'hF, 1'b1, 1'b0);
        n_cmp++; if ({s_cmpdone, cmp_pass} !== 2'b00) begin n_bad++; $display("FAIL cmp_hold: got %b want 00", {s_cmpdone, cmp_pass}); end
        bus(A_ERRC, 0, 4'hF, 1'b0, 1'b0);
        n_cmp++; if (s_dat !== 32'd4) begin n_bad++; $display("FAIL cmp_errcnt2: got %0d want 4", s_dat); end
        bus(A_ERRC, 32'h5A, 4'hF, 1'b1, 1'b0);
        bus(A_ERRC, 0, 4'hF, 1'b0, 1'b0);
        n_cmp++; if (s_dat !== 32'd0) begin n_bad++; $display("FAIL errcnt_clear: got %0d want 0", s_dat); end
    endtask

    task automatic test_fifo();
        bus(A_MSG, 32'h4F, 4'h1, 1'b1, 1'b0);
        bus(A_MSG, 32'h4B, 4'h1, 1'b1, 1'b0);
        bus(A_MSG, 32'h0A, 4'h1, 1'b1, 1'b0);
        bus(A_MSG, 32'h99, 4'hE, 1'b1, 1'b0);
        n_cmp++; if ({msg_level, msg_data, msg_empty} !== {3'd3, 8'h4F, 1'b0}) begin n_bad++; $display("FAIL fifo_fill: got %h want %h", {msg_level, msg_data, msg_empty}, {3'd3, 8'h4F, 1'b0}); end
        bus(A_STAT, 0, 4'hF, 1'b0, 1'b0);
        n_cmp++; if (s_dat !== 32'h00000300) begin n_bad++; $display("FAIL fifo_status: got %h want 00000300", s_dat); end
        n_cmp++; if (msg_data !== 8'h4F) begin n_bad++; $display("FAIL fifo_pop0: got %h want 4f", msg_data); end
        pop_one();
        n_cmp++; if (msg_data !== 8'h4B) begin n_bad++; $display("FAIL fifo_pop1: got %h want 4b", msg_data); end
        pop_one();
        n_cmp++; if (msg_data !== 8'h0A) begin n_bad++; $display("FAIL fifo_pop2: got %h want 0a", msg_data); end
        pop_one();
        pop_one();
        n_cmp++; if ({msg_empty, msg_level} !== {1'b1, 3'd0}) begin n_bad++; $display("FAIL fifo_empty: got %h want %h", {msg_empty, msg_level}, {1'b1, 3'd0}); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) bus(A_MSG, 32'h11 * i, 4'h1, 1'b1, 1'b0);
        bus(A_STAT, 0, 4'hF, 1'b0, 1'b0);
        n_cmp++; if (s_dat !== 32'h00000406) begin n_bad++; $display("FAIL ovf_status: got %h want 00000406", s_dat); end
        bus(A_MSG, 32'h66, 4'h1, 1'b1, 1'b1);
        n_cmp++; if ({msg_full, msg_level, msg_data} !== {1'b1, 3'd4, 8'h22}) begin n_bad++; $display("FAIL ovf_push_pop: got %h want %h", {msg_full, msg_level, msg_data}, {1'b1, 3'd4, 8'h22}); end
        bus(A_STAT, 0, 4'hF, 1'b0, 1'b0);
        n_cmp++; if (s_dat !== 32'h00000406) begin n_bad++; $display("FAIL ovf_sticky: got %h want 00000406", s_dat); end
        bus(A_STAT, 32'h4, 4'hF, 1'b1, 1'b0);
        bus(A_STAT, 0, 4'hF, 1'b0, 1'b0);
        n_cmp++; if (s_dat !== 32'h00000402) begin n_bad++; $display("FAIL ovf_clear: got %h want 00000402", s_dat); end
        for (int i = 0; i < 4; i++) begin
            logic [7:0] want;
            want = (i == 3) ? 8'h66 : 8'(8'h22 + 8'h11 * i);
            n_cmp++; if (msg_data !== want) begin n_bad++; $display("FAIL ovf_drain%0d: got %h want %h", i, msg_data, want); end
            pop_one();
        end
    endtask

    task automatic test_err_offset();
        bus(32'h20, 0, 4'hF, 1'b0, 1'b0);
        n_cmp++; if ({s_err, s_ack, s_dat, n_err} !== 35'h4_0000_0000) begin n_bad++; $display("FAIL err_read: got %h want 400000000", {s_err, s_ack, s_dat, n_err}); end
        bus(32'h18, 32'hFF, 4'hF, 1'b1, 1'b0);
        n_cmp++; if ({s_err, s_ack, s_evt} !== 5'b10000) begin n_bad++; $display("FAIL err_write: got %b want 10000", {s_err, s_ack, s_evt}); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] acks;
        logic [31:0] d1;
        adr = A_EXP; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            acks[i] = ack;
            if (i == 0) d1 = rdat;
            if (i == 2) begin cyc = 1'b0; stb = 1'b0; end
        end
        n_cmp++; if (acks !== 4'b0101) begin n_bad++; $display("FAIL b2b_acks: got %b want 0101", acks); end
        n_cmp++; if (d1 !== 32'h12345678) begin n_bad++; $display("FAIL b2b_data: got %h want 12345678", d1); end
        adr = A_CTRL; wdat = 32'h4; we = 1'b1; cyc = 1'b0; stb = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if ({ack, err, evt_err} !== 3'b000) begin n_bad++; $display("FAIL no_cyc: got %b want 000", {ack, err, evt_err}); end
        stb = 1'b0; we = 1'b0;
        bus(A_ERRC, 0, 4'hF, 1'b0, 1'b0);
        n_cmp++; if (s_dat !== 32'd0) begin n_bad++; $display("FAIL no_cyc_errcnt: got %0d want 0", s_dat); end
    endtask

    task automatic test_flush();
        bus(A_MSG, 32'hA1, 4'h1, 1'b1, 1'b0);
        bus(A_MSG, 32'hA2, 4'h1, 1'b1, 1'b0);
        bus(A_CTRL, 32'h10, 4'hF, 1'b1, 1'b1);
        n_cmp++; if ({msg_level, msg_empty} !== {3'd0, 1'b1}) begin n_bad++; $display("FAIL flush_level: got %h want %h", {msg_level, msg_empty}, {3'd0, 1'b1}); end
        for (int i = 0; i < 5; i++) bus(A_MSG, 32'hB0 + i, 4'h1, 1'b1, 1'b0);
        bus(A_CTRL, 32'h10, 4'hF, 1'b1, 1'b0);
        bus(A_STAT, 0, 4'hF, 1'b0, 1'b0);
        n_cmp++; if (s_dat !== 32'h00000005) begin n_bad++; $display("FAIL flush_keeps_ovf: got %h want 00000005", s_dat); end
        bus(A_STAT, 32'h4, 4'hF, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        bus(A_EXP, 32'h0, 4'h1, 1'b1, 1'b0);
        bus(A_CTRL, 32'h8, 4'hF, 1'b1, 1'b0);
        n_cmp++; if (s_cmppass !== 1'b1) begin n_bad++; $display("FAIL pre_reset_pass: got %b want 1", s_cmppass); end
        bus(A_MSG, 32'h77, 4'h1, 1'b1, 1'b0);
        adr = A_CTRL; wdat = 32'h9; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if ({ack, err, rdat, evt_rep, cmp_done, cmp_pass} !== 37'h0) begin n_bad++; $display("FAIL midrst_bus: got %h want 0", {ack, err, rdat, evt_rep, cmp_done, cmp_pass}); end
        n_cmp++; if ({msg_empty, msg_full, msg_level, msg_data} !== {1'b1, 1'b0, 3'd0, 8'h00}) begin n_bad++; $display("FAIL midrst_fifo: got %h want %h", {msg_empty, msg_full, msg_level, msg_data}, {1'b1, 1'b0, 3'd0, 8'h00}); end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if ({ack, evt_rep} !== 2'b00) begin n_bad++; $display("FAIL midrst_no_ack: got %b want 00", {ack, evt_rep}); end
        bus(A_EXP, 0, 4'hF, 1'b0, 1'b0);
        n_cmp++; if (s_dat !== 32'h0) begin n_bad++; $display("FAIL midrst_exp: got %h want 0", s_dat); end
    endtask

    initial begin
        rst = 1'b1; adr = '0; wdat = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0; msg_rd = 1'b0;
        test_reset();
        test_events();
        test_compare();
        test_fifo();
        test_overflow();
        test_err_offset();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fw_mailbox_wb.md
# fw_mailbox_wb

Parametrised Wishbone slave that firmware running on the SoC CPU uses to report test progress to the simulation testbench. It is the successor to the single-register firmware interface. It adds:
- a registered, single-cycle ack with error response,
- byte-lane writes,
- a message-character FIFO drained by the testbench,
- a hardware expected/measured compare with mismatch counting.

It sits on the SoC Wishbone interconnect as a testbench-only peripheral.

## Interface
Parameters:
- FIFO_DEPTH, 64, message FIFO entries (8-bit each); power of two, ≥2
- ADDR_WIDTH, 8, decoded low address bits; word offset = wb_adr_i[ADDR_WIDTH-1:2]
- CNT_WIDTH, 16, width of error/mismatch counters; saturating

Ports (one clock; reset is synchronous and active-high):
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- wb_adr_i  in  32  address; only [ADDR_WIDTH-1:2] decoded
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte lane selects
- wb_we_i  in  1  write enable
- wb_cyc_i, wb_stb_i  in  1 each  bus cycle / strobe
- wb_ack_o  out  1  registered ack
- wb_err_o  out  1  registered error (unmapped offset)
- wb_dat_o  out  32  registered read data
- evt_report_o, evt_warning_o, evt_error_o  out  1 each  one-cycle event pulses
- cmp_done_o  out  1  one-cycle pulse when a compare executes
- cmp_pass_o  out  1  result of the last compare; held until the next compare
- msg_rd_i  in  1  testbench pop request
- msg_data_o  out  8  FIFO head byte; valid when !msg_empty_o
- msg_empty_o, msg_full_o  out  1 each  FIFO flags
- msg_level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

## Operation
Register map (byte offset):
- 0x00 CONTROL, W.
  - bit0 report, bit1 warning, bit2 error: pulse the matching evt_*_o.
  - bit3 compare: cmp_pass_o <= (EXPECTED==MEASURED).
  - bit4 flush FIFO.
  - Several bits in one write all take effect. Reads return 0.
- 0x04 STATUS, R.
  - bit0 empty, bit1 full, bit2 overflow (sticky).
  - [15:8] level, zero-extended or truncated to 8 bits.
  - Writing 1 to bit2 clears overflow.
- 0x08 EXPECTED, RW. 0x0C MEASURED, RW.
  - Per-byte write: lane n is written only when wb_sel_i[n]=1.
- 0x10 MSG_DATA, W.
  - If wb_sel_i[0]=1, push wb_dat_i[7:0]; if wb_sel_i[0]=0, no push. Reads return 0.
- 0x14 ERR_COUNT, R.
  - [CNT_WIDTH-1:0] counts error events plus failed compares.
  - Any write clears it.
- Any other offset: respond with wb_err_o instead of wb_ack_o; no side effects; wb_dat_o=0.

Counters:
- ERR_COUNT adds 1 for an error event and 1 for a failed compare (+2 if both occur in the same write).
- ERR_COUNT saturates at all-ones.

FIFO:
- Push and pop use independent pointers, which wrap modulo FIFO_DEPTH.
- Pop when empty: ignored.
- Push when full and no pop that cycle: byte dropped, overflow set.
- Push and pop in the same cycle while full: both occur; level unchanged; no overflow.
- Push and pop in the same cycle while empty: the push occurs; the pop is ignored.
- Flush overrides any same-cycle push and pop; level becomes 0. Flush does not clear overflow.

## Timing
Bus access:
- An access is accepted in the cycle where cyc & stb & !ack_o & !err_o.
- All side effects (register write, push, events, compare, counter update) commit on that clock edge.
- wb_ack_o or wb_err_o is high for exactly one cycle after acceptance, together with wb_dat_o. Latency is 1 cycle.
- The cycle after ack, the slave accepts nothing even if stb is still high. The next access can be accepted 2 cycles after the previous one.
- If cyc or stb drops before ack, nothing is accepted.

Read data:
- Reads capture register values as they were before any same-cycle update.
- STATUS and level reflect FIFO state before that edge.

Outputs:
- evt_*_o and cmp_done_o are asserted in the same cycle as wb_ack_o.
- cmp_pass_o updates on that edge.
- msg_data_o is combinational from the head entry. A pop takes effect on the edge where msg_rd_i=1.
- msg_level_o, msg_empty_o and msg_full_o are registered or derived from registered pointers, with no extra latency.

Reset (synchronous, active-high):
- All outputs are 0 except msg_empty_o=1.
- EXPECTED, MEASURED, ERR_COUNT, overflow and pointers are 0; cmp_pass_o=0.
- Reset in the middle of an access aborts it; no ack is issued.
- The FIFO is emptied on reset.

## Test plan
- Write 0x00000007 to CONTROL with sel=0xF. Required: ack 1 cycle later; evt_report, evt_warning and evt_error each pulse for one cycle; ERR_COUNT reads 1.
- Write EXPECTED=0x12345678 (sel=0xF), then MEASURED=0xAB345678 with sel=0x7; read MEASURED → 0x00345678. Write CONTROL=0x8. Required: cmp_done pulses; cmp_pass_o=0; ERR_COUNT increments.
- Push "OK\n" to MSG_DATA. Required: msg_level_o=3, head=0x4F. Pop three times → 0x4F, 0x4B, 0x0A; then msg_empty_o=1.
- With FIFO_DEPTH=4:
  - push 5 bytes → full=1, STATUS bit2=1, 5th byte dropped;
  - next push together with msg_rd_i → level stays 4, overflow unchanged;
  - write 0x4 to STATUS → overflow clears.
- Access offset 0x20. Required: wb_err_o one cycle, no ack, wb_dat_o=0. Hold stb high for 3 cycles on a valid register. Required: ack at cycles 2 and 4 only.
- Push 2 bytes, then write CONTROL=0x10 in the same cycle as msg_rd_i=1. Required: level=0. Assert reset mid-access. Required: no ack; all outputs at their reset values on the next cycle.
